// File: rtl/pwr_req_pkg.sv
// Shared types and constants for the power-mode handshake initiator.
package pwr_req_pkg;

  typedef enum logic [1:0] {
    REQ_ON,
    REQ_SLEEP,
    REQ_OFF,
    REQ_WAKE
  } pwr_req_state_e;

  localparam logic MODE_D1_OFF = 1'b0;
  localparam logic MODE_D1_ON  = 1'b1;

  localparam int ERR_TIMEOUT   = 0;
  localparam int ERR_UNEXP_ACK = 1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds once it reaches MAX.
module sat_counter #(
  parameter int unsigned MAX = 16,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = W'(MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pwr_mode_requester.sv
// Initiator of the mode/mode_req/mode_ack handshake: requests D1 power-down after
// an idle period and wake-up on activity, flagging ack timeouts and stray acks.
//   state     | meaning
//   REQ_ON    | D1 usable, counting idle cycles
//   REQ_SLEEP | power-down requested, waiting for ack
//   REQ_OFF   | D1 off, waiting for a wake reason
//   REQ_WAKE  | power-up requested, waiting for ack
module pwr_mode_requester
  import pwr_req_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       activity,
  input  logic       wake_req,
  input  logic       sleep_allow,
  input  logic       err_clr,
  input  logic       mode_ack,
  output logic       mode,
  output logic       mode_req,
  output logic       d1_on,
  output logic       stall,
  output logic [1:0] err
);

  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

  pwr_req_state_e state_q, state_d;
  logic           pend_q, pend_d;
  logic [1:0]     err_q, err_d;
  logic           mode_q, mode_d;
  logic           mode_req_q, mode_req_d;
  logic           d1_on_q, d1_on_d;
  logic           stall_q, stall_d;

  logic           idle_clr, idle_inc;
  logic           ack_clr, ack_inc;
  logic [IW-1:0]  idle_cnt;
  logic [AW-1:0]  ack_cnt;
  logic           idle_cycle, in_req_q, in_req_d;
  logic           timeout_set, unexp_ack;

  sat_counter #(.MAX(IDLE_CYCLES), .W(IW)) u_idle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (idle_clr),
    .inc   (idle_inc),
    .cnt   (idle_cnt)
  );

  sat_counter #(.MAX(ACK_TIMEOUT), .W(AW)) u_ack_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (ack_clr),
    .inc   (ack_inc),
    .cnt   (ack_cnt)
  );

  assign idle_cycle = ~activity & ~wake_req & sleep_allow;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    idle_clr  = 1'b1;
    idle_inc  = 1'b0;
    unexp_ack = 1'b0;
    case (state_q)
      REQ_ON: begin
        unexp_ack = mode_ack;
        if (idle_cycle) begin
          idle_clr = 1'b0;
          idle_inc = 1'b1;
          if (idle_cnt == IDLE_LAST) state_d = REQ_SLEEP;
        end
      end
      REQ_SLEEP: begin
        if (activity || wake_req) pend_d = 1'b1;
        if (mode_ack) state_d = REQ_OFF;
      end
      REQ_OFF: begin
        unexp_ack = mode_ack;
        if (pend_q || wake_req || activity) begin
          state_d = REQ_WAKE;
          pend_d  = 1'b0;
        end
      end
      REQ_WAKE: begin
        if (mode_ack) state_d = REQ_ON;
      end
      default: state_d = REQ_ON;
    endcase

    // Ack counter holds the number of request cycles including the current one.
    in_req_q    = (state_q == REQ_SLEEP) || (state_q == REQ_WAKE);
    in_req_d    = (state_d == REQ_SLEEP) || (state_d == REQ_WAKE);
    ack_clr     = ~in_req_d;
    ack_inc     = in_req_d;
    timeout_set = in_req_q && ~mode_ack && (ack_cnt == ACK_LAST);

    err_d                = err_q & {2{~err_clr}};
    err_d[ERR_TIMEOUT]   = err_d[ERR_TIMEOUT] | timeout_set;
    err_d[ERR_UNEXP_ACK] = err_d[ERR_UNEXP_ACK] | unexp_ack;

    mode_d     = ((state_d == REQ_ON) || (state_d == REQ_WAKE)) ? MODE_D1_ON : MODE_D1_OFF;
    mode_req_d = in_req_d;
    d1_on_d    = (state_d == REQ_ON);
    stall_d    = ~d1_on_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= REQ_ON;
      pend_q     <= 1'b0;
      err_q      <= '0;
      mode_q     <= MODE_D1_ON;
      mode_req_q <= 1'b0;
      d1_on_q    <= 1'b1;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      mode_q     <= mode_d;
      mode_req_q <= mode_req_d;
      d1_on_q    <= d1_on_d;
      stall_q    <= stall_d;
    end
  end

  assign mode     = mode_q;
  assign mode_req = mode_req_q;
  assign d1_on    = d1_on_q;
  assign stall    = stall_q;
  assign err      = err_q;

endmodule

// File: doc/pwr_mode_requester.md
# pwr_mode_requester

Initiator side of the `mode`/`mode_req`/`mode_ack` power-mode handshake; the PMU FSM is the responder. Watches datapath activity and requests D1 power-down after a programmable idle period. Requests wake-up on activity or an explicit wake request. Drives upstream stall while D1 is unavailable and flags handshake faults.

## Interface
- `IDLE_CYCLES`, 16: consecutive idle cycles before a sleep request; legal range ≥2.
- `ACK_TIMEOUT`, 64: request cycles without `mode_ack` before a timeout is flagged; legal range ≥8.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `activity`  in  1  datapath enable (`en`); high means the cycle is not idle.
- `wake_req`  in  1  external wake request, level.
- `sleep_allow`  in  1  software permission to power down; low holds the idle counter at 0.
- `err_clr`  in  1  clears both sticky error bits.
- `mode_ack`  in  1  single-cycle acknowledge pulse from the PMU.
- `mode`  out  1  target mode: 0 = D1 off, 1 = D1 on.
- `mode_req`  out  1  request level to the PMU.
- `d1_on`  out  1  D1 usable; low from the start of a sleep request until the wake ack.
- `stall`  out  1  equals `~d1_on`; upstream holds `activity` low.
- `err`  out  2  sticky flags: [0] ack timeout, [1] unexpected ack.

## Operation
- All outputs are registered.
- Reset values: `mode`=1, `mode_req`=0, `d1_on`=1, `stall`=0, `err`=0. State after reset is ON.
- Reset mid-handshake returns to ON immediately. The PMU must share the same reset.
- State ON: `mode`=1, `mode_req`=0.
  - Idle counter increments on cycles with `activity`=0, `wake_req`=0 and `sleep_allow`=1.
  - Any other cycle clears the idle counter.
  - When the counter reaches `IDLE_CYCLES`, go to SLEEP_REQ.
- State SLEEP_REQ: `mode`=0, `mode_req`=1, `d1_on`=0.
  - Any `activity` or `wake_req` seen here sets a pending-wake bit.
  - On `mode_ack`, go to OFF.
- State OFF: `mode`=0, `mode_req`=0.
  - If pending wake is set, `wake_req`=1, or `activity`=1, go to WAKE_REQ next cycle and clear pending wake.
- State WAKE_REQ: `mode`=1, `mode_req`=1.
  - Wake requests arriving here are absorbed.
  - On `mode_ack`, go to ON and clear the idle counter.
- Request rules:
  - `mode_req` deasserts the cycle after the ack is seen.
  - `mode_req` is low for at least one cycle between consecutive requests.
  - `mode` never changes while `mode_req`=1.
- Timeout:
  - The ack counter clears on entry to SLEEP_REQ or WAKE_REQ and counts each cycle spent in those states.
  - At `ACK_TIMEOUT`, set `err[0]`. The counter saturates.
  - The handshake is not aborted: the PMU sequence cannot be cancelled, so the block keeps waiting.
- A `mode_ack` seen in ON or OFF sets `err[1]` and is otherwise ignored.
- If an error set and `err_clr` occur in the same cycle, set wins.

## Timing
- Sleep entry: `activity` low in cycles t..t+IDLE_CYCLES-1 gives `mode_req`=1 and `mode`=0 at t+IDLE_CYCLES.
- With the PMU responder, the ack arrives 5 cycles after the first `mode_req` cycle (PMU S1..S4 plus its output register).
- Sleep ack at cycle a: state is OFF with `mode_req`=0 at a+1.
- Earliest wake `mode_req` is at a+2.
- Wake ack at cycle b: `d1_on`=1, `stall`=0 and `mode_req`=0 at b+1.
- Minimum sleep/wake round trip: 13 cycles from the first sleep request cycle to `d1_on` high.

## Structure
- Package `pwr_req_pkg`:
  - enum `pwr_req_state_e` {REQ_ON, REQ_SLEEP, REQ_OFF, REQ_WAKE}
  - constants `MODE_D1_OFF`=0, `MODE_D1_ON`=1
  - error bit indices `ERR_TIMEOUT`=0, `ERR_UNEXP_ACK`=1
- Sub-module `sat_counter`: parameterised width, `clr`/`inc` inputs, saturating. Instantiated twice, for the idle count and the ack timeout.
- Counter widths are `$clog2(param+1)`.

## Test plan
- Idle entry: reset, `sleep_allow`=1, `activity`=0. Expect `mode_req`=1 and `mode`=0 at cycle 16. Responder acks 5 cycles later. Expect `mode_req`=0 and `d1_on`=0 the next cycle.
- Activity at cycle 10 of the idle window restarts the count. Expect the request 16 cycles after activity drops.
- Wake in SLEEP_REQ: `wake_req` pulse 2 cycles after the sleep request. After the sleep ack, expect one OFF cycle, then a wake `mode_req` with `mode`=1. After the wake ack, `d1_on`=1.
- Timeout: responder never acks. Expect `err[0]`=1 at request cycle 64 with `mode_req` still 1. A late ack completes the handshake. Then `err_clr` gives `err`=0.
- Unexpected ack: `mode_ack` pulse in ON. Expect `err[1]`=1 and no state change. `err_clr` together with a second spurious ack leaves `err[1]`=1.
- Reset mid-handshake: assert `reset` in WAKE_REQ. The next cycle shows all outputs at reset values. The PMU reset alongside produces no spurious request.
